// File: rtl/testeio_dp_mem_pipelined.sv
// testeio_dp_mem_pipelined: true-dual-port Avalon-MM RAM with pipelined read returns,
// byte-merged cross-port forwarding, collision flag and a post-reset zero-fill sequencer.
module testeio_dp_mem_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 15,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [ADDR_WIDTH-1:0]   address2,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH/8-1:0] byteenable2,
    input  logic                    chipselect,
    input  logic                    chipselect2,
    input  logic                    read,
    input  logic                    read2,
    input  logic                    write,
    input  logic                    write2,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic [DATA_WIDTH-1:0]   writedata2,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic [DATA_WIDTH-1:0]   readdata2,
    output logic                    readdatavalid,
    output logic                    readdatavalid2,
    output logic                    waitrequest,
    output logic                    waitrequest2,
    output logic                    clear_busy,
    output logic                    collision
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {READY, CLEAR} state_t;

    state_t                                  state;
    logic [ADDR_WIDTH-1:0]                   cnt;
    logic [DATA_WIDTH-1:0]                   mem [DEPTH];
    logic [DATA_WIDTH-1:0]                   word1, word2;
    logic [READ_LATENCY-1:0]                 vld1, vld2;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pipe1, pipe2;
    logic                                    stall, wr1, wr2, rd1, rd2;

    assign stall          = ~clken | reset_req | clear_busy;
    assign wr1            = chipselect & write & ~stall;
    assign wr2            = chipselect2 & write2 & ~stall;
    assign rd1            = chipselect & read & ~write & ~stall;
    assign rd2            = chipselect2 & read2 & ~write2 & ~stall;
    assign waitrequest    = stall;
    assign waitrequest2   = stall;
    assign readdata       = pipe1[READ_LATENCY-1];
    assign readdata2      = pipe2[READ_LATENCY-1];
    // a return parked in the last stage is only presented once the fabric is unstalled
    assign readdatavalid  = vld1[READ_LATENCY-1] & ~stall;
    assign readdatavalid2 = vld2[READ_LATENCY-1] & ~stall;

    // post-write image of each addressed word: serves both the write port and
    // mixed-port read-during-write; port 1 lanes override port 2 on overlap
    always_comb begin
        word1 = mem[address];
        word2 = mem[address2];
        for (int i = 0; i < NB; i++) begin
            if (wr2 && byteenable2[i]) begin
                if (address2 == address) word1[8*i +: 8] = writedata2[8*i +: 8];
                word2[8*i +: 8] = writedata2[8*i +: 8];
            end
            if (wr1 && byteenable[i]) begin
                word1[8*i +: 8] = writedata[8*i +: 8];
                if (address == address2) word2[8*i +: 8] = writedata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[cnt] <= '0;
        if (wr1) mem[address] <= word1;
        if (wr2) mem[address2] <= word2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt        <= '0;
            clear_busy <= (CLEAR_ON_RESET != 0);
        end else if (state == CLEAR) begin
            cnt <= cnt + ADDR_WIDTH'(1);
            if (&cnt) begin
                state      <= READY;
                clear_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld1      <= '0;
            vld2      <= '0;
            pipe1     <= '0;
            pipe2     <= '0;
            collision <= 1'b0;
        end else begin
            collision <= wr1 & wr2 & (address == address2) & (|(byteenable & byteenable2));
            if (!stall) begin
                vld1[0]  <= rd1;
                vld2[0]  <= rd2;
                pipe1[0] <= word1;
                pipe2[0] <= word2;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    vld1[i]  <= vld1[i-1];
                    vld2[i]  <= vld2[i-1];
                    pipe1[i] <= pipe1[i-1];
                    pipe2[i] <= pipe2[i-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_testeio_dp_mem_pipelined.sv
// tb_testeio_dp_mem_pipelined: drives a latency-1 and a latency-2 instance with identical
// traffic and compares every cycle against an array/log based memory model.
module tb_testeio_dp_mem_pipelined;
    logic        clk = 1'b0, reset = 1'b1, clken = 1'b1, reset_req = 1'b0;
    logic [3:0]  addr1 = '0, addr2 = '0, be1 = '0, be2 = '0;
    logic        cs1 = 1'b0, cs2 = 1'b0, rd1 = 1'b0, rd2 = 1'b0, wr1 = 1'b0, wr2 = 1'b0;
    logic [31:0] wd1 = '0, wd2 = '0;
    logic [31:0] q_a1, q_a2, q_b1, q_b2;
    logic        v_a1, v_a2, v_b1, v_b2, w_a1, w_a2, w_b1, w_b2;
    logic        busy_a, busy_b, col_a, col_b;

    logic [31:0] ref_mem [16];
    int          acc_t [2][8192];
    logic [31:0] acc_d [2][8192];
    int          n_acc [2];
    int          n_ret [2][2];
    logic [31:0] last [2][2];
    int          ucnt, clr_left, busy_seen, str_cnt, stall_str, checks, errors;
    logic        exp_col;

    always #5 clk = ~clk;

    testeio_dp_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .address(addr1), .address2(addr2), .byteenable(be1), .byteenable2(be2),
        .chipselect(cs1), .chipselect2(cs2), .read(rd1), .read2(rd2), .write(wr1), .write2(wr2),
        .writedata(wd1), .writedata2(wd2), .readdata(q_a1), .readdata2(q_a2),
        .readdatavalid(v_a1), .readdatavalid2(v_a2), .waitrequest(w_a1), .waitrequest2(w_a2),
        .clear_busy(busy_a), .collision(col_a));

    testeio_dp_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .address(addr1), .address2(addr2), .byteenable(be1), .byteenable2(be2),
        .chipselect(cs1), .chipselect2(cs2), .read(rd1), .read2(rd2), .write(wr1), .write2(wr2),
        .writedata(wd1), .writedata2(wd2), .readdata(q_b1), .readdata2(q_b2),
        .readdatavalid(v_b1), .readdatavalid2(v_b2), .waitrequest(w_b1), .waitrequest2(w_b2),
        .clear_busy(busy_b), .collision(col_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (wd & m);
    endfunction

    task automatic idle();
        cs1 = 1'b0; cs2 = 1'b0; rd1 = 1'b0; rd2 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
    endtask

    task automatic log_read(input int p, input logic [31:0] d);
        if (n_acc[p] < 8192) begin
            acc_t[p][n_acc[p]] = ucnt;
            acc_d[p][n_acc[p]] = d;
            n_acc[p]++;
        end
    endtask

    task automatic step();
        logic        stall, e, w1, w2, r1, r2;
        logic [31:0] d [2][2];
        logic        v [2][2];
        logic        wq [2][2];
        logic        bs [2];
        logic        cl [2];
        logic [31:0] nm [16];
        @(negedge clk);
        stall = !clken || reset_req || (clr_left > 0);
        d  = '{'{q_a1, q_a2}, '{q_b1, q_b2}};
        v  = '{'{v_a1, v_a2}, '{v_b1, v_b2}};
        wq = '{'{w_a1, w_a2}, '{w_b1, w_b2}};
        bs = '{busy_a, busy_b};
        cl = '{col_a, col_b};
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("clear_busy_l%0d", k + 1), bs[k], clr_left > 0);
            chk($sformatf("collision_l%0d", k + 1), cl[k], exp_col);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("waitrequest_l%0d_p%0d", k + 1, p + 1), wq[k][p], stall);
                e = !stall && n_ret[k][p] < n_acc[p] && acc_t[p][n_ret[k][p]] + k + 1 == ucnt;
                chk($sformatf("readdatavalid_l%0d_p%0d", k + 1, p + 1), v[k][p], e);
                if (e) begin
                    chk($sformatf("readdata_l%0d_p%0d", k + 1, p + 1), d[k][p], acc_d[p][n_ret[k][p]]);
                    last[k][p] = d[k][p];
                    n_ret[k][p]++;
                end
            end
        end
        if (v_a1) begin
            str_cnt++;
            if (stall) stall_str++;
        end
        if (busy_a) busy_seen++;
        w1 = cs1 && wr1 && !stall;
        w2 = cs2 && wr2 && !stall;
        r1 = cs1 && rd1 && !wr1 && !stall;
        r2 = cs2 && rd2 && !wr2 && !stall;
        nm = ref_mem;
        if (w2) nm[addr2] = merge(nm[addr2], wd2, be2);
        if (w1) nm[addr1] = merge(nm[addr1], wd1, be1);
        if (r1) log_read(0, nm[addr1]);
        if (r2) log_read(1, nm[addr2]);
        exp_col = w1 && w2 && addr1 == addr2 && (be1 & be2) != 4'b0;
        ref_mem = nm;
        if (!stall) ucnt++;
        if (clr_left > 0) clr_left--;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        clken = 1'b1;
        reset_req = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readdata_l1_p1", q_a1, 32'h0);
        chk("rst_readdata_l1_p2", q_a2, 32'h0);
        chk("rst_readdata_l2_p1", q_b1, 32'h0);
        chk("rst_readdata_l2_p2", q_b2, 32'h0);
        chk("rst_valid", {v_a1, v_a2, v_b1, v_b2}, 4'b0000);
        chk("rst_waitrequest", {w_a1, w_a2, w_b1, w_b2}, 4'b1111);
        chk("rst_clear_busy", {busy_a, busy_b}, 2'b11);
        chk("rst_collision", {col_a, col_b}, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) n_ret[k][p] = n_acc[p];
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        exp_col = 1'b0;
        clr_left = 16;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; ucnt = 0; clr_left = 0; exp_col = 1'b0;
        n_acc = '{0, 0};
        n_ret = '{'{0, 0}, '{0, 0}};
        do_reset();
        busy_seen = 0;
        repeat (20) step();
        chk("clear_len", busy_seen, 16);
        for (int i = 0; i < 16; i++) begin
            cs1 = 1'b1; rd1 = 1'b1; addr1 = 4'(i);
            step();
        end
        idle();
        repeat (3) step();
        chk("readback_all_l1", n_ret[0][0], 16);
        chk("readback_all_l2", n_ret[1][0], 16);

        cs1 = 1'b1; wr1 = 1'b1; addr1 = 4'd3; wd1 = 32'h11223344; be1 = 4'hF;
        step();
        wd1 = 32'hDEADBEEF; be1 = 4'b0101;
        step();
        idle();
        cs2 = 1'b1; rd2 = 1'b1; addr2 = 4'd3;
        step();
        idle();
        repeat (3) step();
        chk("be_merge_l1", last[0][1], 32'h11AD33EF);
        chk("be_merge_l2", last[1][1], 32'h11AD33EF);

        cs1 = 1'b1; wr1 = 1'b1; addr1 = 4'd7; wd1 = 32'hAAAAAAAA; be1 = 4'b0011;
        cs2 = 1'b1; wr2 = 1'b1; addr2 = 4'd7; wd2 = 32'h55555555; be2 = 4'b1110;
        step();
        idle();
        chk("collision_pulse", {col_a, col_b}, 2'b11);
        step();
        cs1 = 1'b1; rd1 = 1'b1; addr1 = 4'd7;
        step();
        idle();
        repeat (3) step();
        chk("dual_write_l1", last[0][0], 32'h5555AAAA);
        chk("dual_write_l2", last[1][0], 32'h5555AAAA);

        cs1 = 1'b1; wr1 = 1'b1; addr1 = 4'd9; wd1 = 32'h12345678; be1 = 4'hF;
        cs2 = 1'b1; rd2 = 1'b1; addr2 = 4'd9;
        step();
        idle();
        repeat (3) step();
        chk("rdw_new_l1", last[0][1], 32'h12345678);
        chk("rdw_new_l2", last[1][1], 32'h12345678);

        str_cnt = 0; stall_str = 0;
        cs1 = 1'b1; rd1 = 1'b1; addr1 = 4'd3;
        step();
        addr1 = 4'd7;
        step();
        clken = 1'b0; addr1 = 4'd9;
        repeat (3) step();
        clken = 1'b1;
        step();
        addr1 = 4'd10;
        step();
        idle();
        repeat (4) step();
        chk("burst_strobes", str_cnt, 4);
        chk("stall_strobes", stall_str, 0);
        chk("burst_last", last[0][0], 32'h0);

        cs1 = 1'b1; rd1 = 1'b1; addr1 = 4'd9;
        cs2 = 1'b1; rd2 = 1'b1; addr2 = 4'd7;
        step();
        step();
        do_reset();
        repeat (5) step();
        do_reset();
        busy_seen = 0;
        repeat (20) step();
        chk("clear_restart_len", busy_seen, 16);

        repeat (1500) begin
            cs1 = $urandom_range(0, 3) != 0; rd1 = 1'($urandom); wr1 = $urandom_range(0, 2) == 0;
            cs2 = $urandom_range(0, 3) != 0; rd2 = 1'($urandom); wr2 = $urandom_range(0, 2) == 0;
            addr1 = 4'($urandom); addr2 = 4'($urandom);
            be1 = 4'($urandom); be2 = 4'($urandom);
            wd1 = $urandom; wd2 = $urandom;
            clken = $urandom_range(0, 7) != 0;
            reset_req = $urandom_range(0, 15) == 0;
            step();
        end
        idle();
        clken = 1'b1;
        reset_req = 1'b0;
        repeat (4) step();
        chk("drain_l1_p1", n_ret[0][0], n_acc[0]);
        chk("drain_l1_p2", n_ret[0][1], n_acc[1]);
        chk("drain_l2_p1", n_ret[1][0], n_acc[0]);
        chk("drain_l2_p2", n_ret[1][1], n_acc[1]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
